// File: rtl/burst_scheduler.sv
// Interrupter burst sequencer for the DRSSTC gate drive: bounds on-time, enforces
// off-time, ends bursts on a feedback zero crossing, and locks out after repeated OCD.
module burst_scheduler #(
   parameter int CLK_MHZ         = 100,
   parameter int ON_US_MAX       = 200,
   parameter int OFF_US_MIN      = 1000,
   parameter int STOP_TIMEOUT_US = 4,
   parameter int FAULT_LIMIT     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic ocd,
   input  logic fb,
   output logic en_out,
   output logic busy,
   output logic dropped,
   output logic fault
);

   localparam int ON_CYC   = CLK_MHZ * ON_US_MAX;
   localparam int OFF_CYC  = CLK_MHZ * OFF_US_MIN;
   localparam int STOP_CYC = CLK_MHZ * STOP_TIMEOUT_US;
   localparam int MAX_A    = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int MAX_CYC  = (MAX_A > STOP_CYC) ? MAX_A : STOP_CYC;
   localparam int CW       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int FW       = (FAULT_LIMIT > 0) ? $clog2(FAULT_LIMIT + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ON, S_STOP, S_OFF, S_LOCK} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [FW-1:0]   fault_cnt;
   logic [FW-1:0]   fault_cnt_inc;
   logic            ocd_flag;
   logic            trig_q, fb_q;
   logic            trig_rise, fb_fall;
   logic            stop_done, hit_limit;

   assign trig_rise     = trig & ~trig_q;
   assign fb_fall       = ~fb & fb_q;
   assign stop_done     = fb_fall || (cnt == CW'(STOP_CYC - 1));
   assign fault_cnt_inc = fault_cnt + FW'(1);
   // Only an OCD-terminated burst can push the strike count to the limit.
   assign hit_limit     = ocd_flag && (fault_cnt_inc == FW'(FAULT_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         fault_cnt <= '0;
         ocd_flag  <= 1'b0;
         trig_q    <= 1'b1;
         fb_q      <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state   <= state_nxt;
         trig_q  <= trig;
         fb_q    <= fb;
         dropped <= trig_rise && (state != S_IDLE);
         if (state_nxt != state)
            cnt <= '0;
         else if (state == S_ON || state == S_STOP || state == S_OFF)
            cnt <= cnt + CW'(1);
         if (state == S_IDLE && trig_rise)
            ocd_flag <= 1'b0;
         else if (state == S_ON && ocd)
            ocd_flag <= 1'b1;
         if (state == S_STOP && stop_done)
            fault_cnt <= ocd_flag ? fault_cnt_inc : '0;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (trig_rise) state_nxt = S_ON;
         S_ON: begin
            if (ocd || cnt == CW'(ON_CYC - 1) || !trig)
               state_nxt = S_STOP;
         end
         S_STOP: if (stop_done) state_nxt = hit_limit ? S_LOCK : S_OFF;
         S_OFF:  if (cnt == CW'(OFF_CYC - 1)) state_nxt = S_IDLE;
         S_LOCK: state_nxt = S_LOCK;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Gate enable stays up through STOP so the burst ends at a current zero crossing.
   always_comb begin
      en_out = 1'b0;
      busy   = 1'b0;
      fault  = 1'b0;
      case (state)
         S_ON, S_STOP: begin
            en_out = 1'b1;
            busy   = 1'b1;
         end
         S_OFF:  busy  = 1'b1;
         S_LOCK: fault = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_burst_scheduler.sv
// Randomized and directed bench for burst_scheduler against a countdown-based
// reference model of the burst rules.
module tb_burst_scheduler;

   localparam int ON_CYC   = 100;
   localparam int OFF_CYC  = 50;
   localparam int STOP_CYC = 20;
   localparam int FL       = 3;

   localparam int M_IDLE = 0, M_ON = 1, M_STOP = 2, M_OFF = 3, M_LOCK = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trig = 1'b0;
   logic ocd = 1'b0;
   logic fb = 1'b0;
   logic en_out, busy, dropped, fault;

   burst_scheduler #(
      .CLK_MHZ(10), .ON_US_MAX(10), .OFF_US_MIN(5), .STOP_TIMEOUT_US(2), .FAULT_LIMIT(FL)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .ocd(ocd), .fb(fb),
      .en_out(en_out), .busy(busy), .dropped(dropped), .fault(fault)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: phase plus remaining cycles in that phase
   int ph = M_IDLE;
   int left = 0;
   int strikes = 0;
   bit hit = 0, tprev = 1, fprev = 0, m_drop = 0;

   function automatic void model_reset();
      ph = M_IDLE; left = 0; strikes = 0; hit = 0;
      tprev = 1; fprev = 0; m_drop = 0;
   endfunction

   function automatic void model_step();
      bit rise, fall;
      rise   = trig && !tprev;
      fall   = !fb && fprev;
      m_drop = rise && (ph != M_IDLE);
      case (ph)
         M_IDLE: if (rise) begin ph = M_ON; left = ON_CYC; hit = 0; end
         M_ON: begin
            if (ocd) begin hit = 1; ph = M_STOP; left = STOP_CYC; end
            else if (left == 1 || !trig) begin ph = M_STOP; left = STOP_CYC; end
            else left--;
         end
         M_STOP: begin
            if (fall || left == 1) begin
               strikes = hit ? strikes + 1 : 0;
               if (strikes == FL) ph = M_LOCK;
               else begin ph = M_OFF; left = OFF_CYC; end
            end else left--;
         end
         M_OFF: if (left == 1) ph = M_IDLE; else left--;
         default: ;
      endcase
      tprev = trig;
      fprev = fb;
   endfunction

   int run = 0, last_len = 0, bursts = 0, drops = 0;
   int fb_half = 0, fb_ph = 0;
   bit prev_en = 0;

   task automatic tick(input int n = 1);
      repeat (n) begin
         if (rst) model_reset(); else model_step();
         @(posedge clk);
         @(negedge clk);
         chk("en_out", en_out, (ph == M_ON || ph == M_STOP));
         chk("busy", busy, (ph == M_ON || ph == M_STOP || ph == M_OFF));
         chk("dropped", dropped, m_drop);
         chk("fault", fault, (ph == M_LOCK));
         if (en_out && !prev_en) bursts++;
         if (!en_out && prev_en) last_len = run;
         run = en_out ? run + 1 : 0;
         prev_en = en_out;
         if (dropped) drops++;
         if (fb_half > 0) begin
            fb_ph++;
            if (fb_ph >= fb_half) begin fb = !fb; fb_ph = 0; end
         end
      end
   endtask

   task automatic ocd_burst();
      trig = 1; tick(3);
      ocd = 1;  tick(1);
      ocd = 0;  tick(2);
      trig = 0; tick(80);
   endtask

   initial begin
      rst = 1; tick(3);
      chk("rst_en", en_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fault", fault, 0);
      rst = 0; tick(5);

      // nominal burst: fb falls once every 10 cycles, so STOP lasts 1..10
      fb_half = 5; fb = 1; fb_ph = 0; drops = 0; bursts = 0;
      trig = 1; tick(40);
      trig = 0; tick(12);
      chk("nom_len_range", (last_len >= 41 && last_len <= 50), 1);
      tick(70);
      chk("nom_idle", busy, 0);
      chk("nom_drops", drops, 0);
      chk("nom_bursts", bursts, 1);
      chk("nom_fault", fault, 0);

      // on-time limit: fb falls on the 3rd STOP cycle
      fb_half = 0; fb = 1; bursts = 0;
      trig = 1; tick(103);
      fb = 0;   tick(397);
      chk("ontime_len", last_len, 103);
      chk("ontime_bursts", bursts, 1);
      trig = 0; tick(80);

      // stop timeout with fb held low
      fb = 0;
      trig = 1; tick(10);
      trig = 0; tick(25);
      chk("stop_to_len", last_len, 30);
      tick(60);

      // duty limit
      fb_half = 2; drops = 0; bursts = 0;
      repeat (10) begin
         trig = 1; tick(5);
         trig = 0; tick(25);
      end
      chk("duty_drops", (drops > 0), 1);
      chk("duty_bursts", (bursts >= 2), 1);
      tick(80);

      // OCD lockout
      repeat (3) ocd_burst();
      chk("lock_fault", fault, 1);
      chk("lock_busy", busy, 0);
      bursts = 0; drops = 0;
      repeat (3) begin
         trig = 1; tick(4);
         trig = 0; tick(4);
      end
      chk("lock_drops", drops, 3);
      chk("lock_bursts", bursts, 0);
      rst = 1; tick(1);
      rst = 0; tick(2);
      chk("lock_clr", fault, 0);

      // strike count cleared by a clean burst
      ocd_burst(); ocd_burst();
      trig = 1; tick(6);
      trig = 0; tick(80);
      ocd_burst(); ocd_burst();
      chk("cnt_clear_fault", fault, 0);

      // trig held high across reset release
      trig = 1; rst = 1; tick(2);
      rst = 0; tick(10);
      chk("trig_hold_en", en_out, 0);
      chk("trig_hold_busy", busy, 0);
      trig = 0; tick(2);

      // reset in ON
      trig = 1; tick(5);
      chk("on_before_rst", en_out, 1);
      rst = 1; tick(1);
      chk("rst_in_on_en", en_out, 0);
      chk("rst_in_on_busy", busy, 0);
      rst = 0; trig = 0; tick(3);

      // random traffic
      fb_half = 0;
      repeat (4000) begin
         if ($urandom_range(0, 19) == 0) trig = !trig;
         ocd = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) fb = !fb;
         rst = ($urandom_range(0, 1999) == 0);
         tick(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
